// File: rtl/and_gate_pkg.sv
// Shared definitions for the and_gate reference cell and its consumers.
package and_gate_pkg;

   localparam int unsigned AND_WIDTH_DEF = 1;
   localparam int unsigned AND_CNT_W_DEF = 16;

   // Type for consumers of hi_count at the default counter width.
   typedef logic [AND_CNT_W_DEF-1:0] and_cnt_t;

endpackage

// File: rtl/and_sat_counter.sv
// Generic saturating up-counter: counts cycles with inc high, sticks at all-ones.
module and_sat_counter
   import and_gate_pkg::*;
#(
   parameter int unsigned CNT_W = AND_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_d;

   // Next count: advance only while below the all-ones ceiling, so it never wraps.
   always_comb begin
      count_d = count;
      if (inc && (count != {CNT_W{1'b1}})) begin
         count_d = count + CNT_W'(1);
      end
   end

   // Count register, cleared immediately on reset regardless of saturation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count_d;
      end
   end

endmodule

// File: rtl/and_gate.sv
// Bitwise two-input AND with a registered copy, rising-edge flag and activity counter.
module and_gate
   import and_gate_pkg::*;
#(
   parameter int unsigned WIDTH = AND_WIDTH_DEF,
   parameter int unsigned CNT_W = AND_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             y_rise,
   output logic [CNT_W-1:0] hi_count
);

   logic             rise_d;
   logic             all_hi;

   // Zero-latency result; deliberately outside reset so it tracks inputs during reset.
   assign y      = a & b;
   assign all_hi = &y;

   // A bit rises when it is 1 now but the registered copy still holds 0.
   always_comb begin
      rise_d = |(y & ~y_q);
   end

   // Registered copy and edge flag share the same edge so the pulse lines up with y_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q    <= '0;
         y_rise <= 1'b0;
      end else begin
         y_q    <= y;
         y_rise <= rise_d;
      end
   end

   and_sat_counter #(
      .CNT_W (CNT_W)
   ) u_hi_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (all_hi),
      .count (hi_count)
   );

endmodule

// File: tb/tb_and_gate.sv
// Directed and randomized checks of and_gate at three parameterizations.
module tb_and_gate;
   import and_gate_pkg::*;

   logic clk = 1'b0;
   logic rst;

   // WIDTH=1, default counter width
   logic     a1, b1, y1, yq1, r1;
   and_cnt_t c1;
   // WIDTH=1, CNT_W=3 for saturation
   logic       a3, b3, y3, yq3, r3;
   logic [2:0] c3;
   // WIDTH=4, default counter width
   logic [3:0]  a4, b4, y4, yq4;
   logic        r4;
   logic [15:0] c4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   and_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(yq1), .y_rise(r1), .hi_count(c1)
   );
   and_gate #(.WIDTH(1), .CNT_W(3)) u_dut3 (
      .clk(clk), .rst(rst), .a(a3), .b(b3), .y(y3), .y_q(yq3), .y_rise(r3), .hi_count(c3)
   );
   and_gate #(.WIDTH(4), .CNT_W(16)) u_dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_q(yq4), .y_rise(r4), .hi_count(c4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit [3:0]  tt_a [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
      bit [3:0]  tt_b [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
      bit [3:0]  tt_y [4] = '{4'd0, 4'd0, 4'd0, 4'd1};
      logic [3:0] m_yq;
      logic [3:0] ey;
      bit         m_rise;
      int         m_cnt;

      rst = 1'b0;
      a1 = 1'b0; b1 = 1'b0; a3 = 1'b0; b3 = 1'b0; a4 = '0; b4 = '0;
      #1 rst = 1'b1;
      #1;
      chk("rst_yq", 32'(yq1), 32'd0);
      chk("rst_rise", 32'(r1), 32'd0);
      chk("rst_cnt", 32'(c1), 32'd0);

      // Truth table, still in reset: y must be valid regardless.
      for (int i = 0; i < 4; i++) begin
         a1 = tt_a[i][0];
         b1 = tt_b[i][0];
         #5;
         chk("truth_y", 32'(y1), 32'(tt_y[i]));
         #5;
      end

      // Register latency from a=b=1 at release.
      a1 = 1'b1; b1 = 1'b1;
      #1 chk("lat_y_imm", 32'(y1), 32'd1);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("lat_yq", 32'(yq1), 32'd1);
      chk("lat_rise", 32'(r1), 32'd1);
      chk("lat_cnt", 32'(c1), 32'd1);
      tick();
      chk("lat_rise_once", 32'(r1), 32'd0);
      chk("lat_yq_hold", 32'(yq1), 32'd1);
      tick(); tick(); tick();
      chk("pre_rst_cnt", 32'(c1), 32'd5);

      // Asynchronous reset mid-cycle.
      #3 rst = 1'b1;
      #1;
      chk("arst_yq", 32'(yq1), 32'd0);
      chk("arst_rise", 32'(r1), 32'd0);
      chk("arst_cnt", 32'(c1), 32'd0);
      chk("arst_y", 32'(y1), 32'd1);

      // Saturation with a 3-bit counter.
      a1 = 1'b0;
      a3 = 1'b1; b3 = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("sat_cnt", 32'(c3), 32'((k < 7) ? k : 7));
      end

      // Multi-bit: partial overlap must not count.
      rst = 1'b1;
      a3 = 1'b0;
      a4 = 4'b1100; b4 = 4'b1010;
      #1 chk("mb_y", 32'(y4), 32'h8);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("mb_cnt_hold0", 32'(c4), 32'd0);
      tick();
      chk("mb_cnt_hold1", 32'(c4), 32'd0);
      a4 = 4'hF; b4 = 4'hF;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("mb_cnt_inc", 32'(c4), 32'(k));
      end

      // X handling: 0 dominates; 1 passes the other operand through.
      a1 = 1'b0; b1 = 1'bx;
      #1 chk("x_zero", 32'(y1), 32'd0);
      a1 = 1'b1;
      #1 chk("x_pass", 32'(y1), 32'(b1));
      b1 = 1'b0;

      // Randomized run on WIDTH=4 against a behavioural model.
      rst = 1'b1;
      a4 = '0; b4 = '0;
      m_yq = '0; m_rise = 1'b0; m_cnt = 0;
      @(negedge clk) rst = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(3) == 0) begin
            a4 = 4'hF; b4 = 4'hF;
         end else begin
            a4 = 4'($urandom); b4 = 4'($urandom);
         end
         for (int j = 0; j < 4; j++) ey[j] = (a4[j] == 1'b1) && (b4[j] == 1'b1);
         #1 chk("rnd_y", 32'(y4), 32'(ey));
         tick();
         m_rise = 1'b0;
         for (int j = 0; j < 4; j++) if (ey[j] && !m_yq[j]) m_rise = 1'b1;
         m_yq = ey;
         if (ey == 4'hF && m_cnt < 65535) m_cnt = m_cnt + 1;
         chk("rnd_yq", 32'(yq4), 32'(m_yq));
         chk("rnd_rise", 32'(r4), 32'(m_rise));
         chk("rnd_cnt", 32'(c4), 32'(m_cnt));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/and_gate.md
# and_gate

Parameterizable bitwise two-input AND primitive with a combinational result and a registered, instrumented copy. It serves as the team's reference logic cell. Downstream logic may consume the zero-latency output `y` or the one-cycle-registered `y_q`. A saturating activity counter and a rising-edge flag support observability and coverage.

## Interface
- `WIDTH`, default 1: operand and result width in bits.
- `CNT_W`, default 16: width of the activity counter.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `a`  input  WIDTH: operand A.
- `b`  input  WIDTH: operand B.
- `y`  output  WIDTH: combinational result `a & b`.
- `y_q`  output  WIDTH: `y` registered by one clock.
- `y_rise`  output  1: one-cycle pulse when any bit of `y_q` goes 0→1.
- `hi_count`  output  CNT_W: saturating count of cycles in which `&y` was 1.

## Operation
- `y[i] = a[i] & b[i]` for every bit i.
  - Purely combinational.
  - Independent of `clk` and `rst`; valid even while in reset.
- Truth table per bit:
  - 0,0 → 0
  - 0,1 → 0
  - 1,0 → 0
  - 1,1 → 1
- X/Z on an input propagates per standard 4-state AND semantics; a 0 on either input forces 0.
- `y_q` captures `y` on each rising `clk` edge.
- `y_rise` is registered: `y_rise` = `|(y & ~y_q)`, sampled at the same edge that updates `y_q`.
- `hi_count` increments by 1 on each edge where the reduction AND of `y` is 1.
  - It holds at all-ones (saturates) and never wraps.
- No enable and no handshake; the block accepts new operands every cycle.

## Timing
- `y`: 0-cycle latency; settles within the same delta and time step as the input change.
- `y_q`: 1-cycle latency.
- `y_rise`: asserted for exactly one cycle, in the cycle `y_q` first shows a new 1 bit.
- `hi_count`: reflects the edge's contribution in the following cycle.
- Reset values, applied immediately on `rst` assertion, no clock needed:
  - `y_q` = 0
  - `y_rise` = 0
  - `hi_count` = 0
- While `rst` is high, state holds its reset value; `y` continues to track `a & b`.
- First edge after deassertion:
  - `y_q` loads `y`.
  - `y_rise` compares against the reset value 0, so a 1 present at deassertion produces a pulse.
- Reset mid-count clears `hi_count` to 0 regardless of saturation.
- At saturation, with `&y` = 1: `hi_count` stays at 2^CNT_W−1.

## Structure
- Shared package `and_gate_pkg` holds:
  - `AND_WIDTH_DEF` = 1
  - `AND_CNT_W_DEF` = 16
  - typedef `and_cnt_t` (logic [CNT_W−1:0]) for consumers of `hi_count`.
- One natural sub-module: `and_sat_counter`, a generic saturating counter with clk, rst, inc, count.
- The AND datapath and the edge detect stay in the top module.

## Test plan
- Truth table, WIDTH=1: apply (a,b) = 00, 01, 10, 11, stepping every 10 time units.
  - Required `y` = 0, 0, 0, 1, checked before each change.
- Reset: assert `rst` asynchronously mid-cycle with `hi_count` = 5 and `y_q` = 1.
  - Required: `y_q`, `y_rise` and `hi_count` go to 0 at once, while `y` still equals `a & b`.
- Register latency: a=b=1 from cycle 0.
  - Required: `y` = 1 immediately, `y_q` = 1 after the first edge, `y_rise` = 1 for exactly that one cycle.
- Saturation, CNT_W=3: hold a=b=1 for 10 cycles.
  - Required `hi_count` sequence 1..7, then held at 7.
- Multi-bit, WIDTH=4: a=4'b1100, b=4'b1010.
  - Required: `y` = 4'b1000 and `hi_count` unchanged.
  - Then a=b=4'hF: `hi_count` increments by 1 per cycle.
- X handling: a=0, b=X gives `y` = 0; a=1, b=X gives `y` = X.
